// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, FSM state
// encodings and the redirect alignment test.
package ifu_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h8000_0000;
  localparam int          FETCH_STATE_WIDTH = 2;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH_RUN  = 2'd0,
    FETCH_HALT = 2'd1,
    FETCH_ERR  = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between the memory
// response channel and decode. Flush has priority over push and pop.
module ifu_inst_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; the head is forced to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word reads to imem,
// queues returned instructions with their PC and hands them to decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                   CPU_WIDTH   = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC    = CPU_WIDTH'(RESET_PC_DEFAULT),
  parameter int                   QUEUE_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_valid,
  input  logic [CPU_WIDTH-1:0]         redirect_pc,
  input  logic                         halt_req,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [CPU_WIDTH-1:0]         imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [CPU_WIDTH-1:0]         imem_rsp_data,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [CPU_WIDTH-1:0]         inst,
  output logic [CPU_WIDTH-1:0]         inst_pc,
  output logic                         misalign_err,
  output logic [FETCH_STATE_WIDTH-1:0] fetch_state
);

  localparam int               CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W:0]   CAP   = QUEUE_DEPTH[CNT_W:0];

  fetch_state_e               state_q;
  fetch_state_e               state_d;
  logic [CPU_WIDTH-1:0]       fetch_pc;
  logic [CPU_WIDTH-1:0]       rsp_pc;
  logic [CNT_W-1:0]           outstanding;
  logic [CNT_W-1:0]           drop_cnt;
  logic [CNT_W-1:0]           q_count;
  logic [CNT_W:0]             occupancy;
  logic [2*CPU_WIDTH-1:0]     q_head;
  logic                       req_fire;
  logic                       push;
  logic                       pop;
  logic                       drop_rsp;

  // In-flight requests plus queued entries never exceed the queue depth,
  // so every response always has a free slot.
  assign occupancy      = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = rst_n & (state_q == FETCH_RUN) & !halt_req
                        & !redirect_valid & (occupancy < CAP);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign drop_rsp   = imem_rsp_valid & (redirect_valid | (drop_cnt != '0));
  assign push       = imem_rsp_valid & !drop_rsp;
  assign inst_valid = (q_count != '0);
  assign pop        = inst_valid & inst_ready;

  assign {inst_pc, inst} = q_head;
  assign misalign_err    = (state_q == FETCH_ERR);
  assign fetch_state     = state_q;

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (is_misaligned(redirect_pc[1:0])) state_d = FETCH_ERR;
      else if (state_q != FETCH_ERR)       state_d = FETCH_RUN;
    end else if (state_q == FETCH_RUN && halt_req) begin
      state_d = FETCH_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + CPU_WIDTH'(4);
        if (push)     rsp_pc   <= rsp_pc + CPU_WIDTH'(4);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  ifu_inst_fifo #(
    .WIDTH (2 * CPU_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

endmodule
